memory_stage: RTL

MEMORY_STAGE -- requirements
Module: memory_stage

---
 rtl/memory_stage.sv | 131 +++++++++++++
 1 files changed

// File: rtl/memory_stage.sv
// Memory pipeline stage. ALU results pass through in one cycle. Loads and stores hold the
// pipeline in ACCESS until the data memory acks, or until a bounded timeout expires.
module memory_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_execute_valid,
    input  logic [7:0]  i_execute_opcode,
    input  logic [3:0]  i_execute_ws,
    input  logic [31:0] i_execute_address,
    input  logic [31:0] i_execute_data,
    output logic        o_stall,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_address,
    output logic [31:0] o_dmem_wdata,
    input  logic        i_dmem_ack,
    input  logic [31:0] i_dmem_rdata,
    output logic [7:0]  o_memory_opcode,
    output logic [3:0]  o_memory_ws,
    output logic [31:0] o_memory_data,
    output logic        o_error
);

    localparam logic [7:0] OpLw  = 8'd1;
    localparam logic [7:0] OpSw  = 8'd2;
    localparam logic [7:0] OpAdd = 8'd3;
    localparam logic [7:0] OpSub = 8'd4;
    localparam logic [7:0] LastCount = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [0:0] {StIdle, StAccess} state_e;

    state_e      r_state, w_state;
    logic [7:0]  r_count, w_count;
    logic        r_is_sw, w_is_sw;
    logic [3:0]  r_ws, w_ws;
    logic [31:0] r_addr, w_addr;
    logic [31:0] r_wdata, w_wdata;
    logic [7:0]  r_mem_op, w_mem_op;
    logic [3:0]  r_mem_ws, w_mem_ws;
    logic [31:0] r_mem_data, w_mem_data;
    logic        r_error, w_error;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= StIdle;
            r_count    <= '0;
            r_is_sw    <= 1'b0;
            r_ws       <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_mem_op   <= '0;
            r_mem_ws   <= '0;
            r_mem_data <= '0;
            r_error    <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_count    <= w_count;
            r_is_sw    <= w_is_sw;
            r_ws       <= w_ws;
            r_addr     <= w_addr;
            r_wdata    <= w_wdata;
            r_mem_op   <= w_mem_op;
            r_mem_ws   <= w_mem_ws;
            r_mem_data <= w_mem_data;
            r_error    <= w_error;
        end
    end

    // Stage result defaults to NOP/0/0 so forwarding never sees a stale load in flight.
    always_comb begin
        w_state    = r_state;
        w_count    = r_count;
        w_is_sw    = r_is_sw;
        w_ws       = r_ws;
        w_addr     = r_addr;
        w_wdata    = r_wdata;
        w_mem_op   = '0;
        w_mem_ws   = '0;
        w_mem_data = '0;
        w_error    = r_error;
        case (r_state)
            StIdle: begin
                if (i_execute_valid) begin
                    case (i_execute_opcode)
                        OpAdd, OpSub: begin
                            w_mem_op   = i_execute_opcode;
                            w_mem_ws   = i_execute_ws;
                            w_mem_data = i_execute_data;
                        end
                        OpLw, OpSw: begin
                            w_is_sw = (i_execute_opcode == OpSw);
                            w_ws    = i_execute_ws;
                            w_addr  = i_execute_address;
                            w_wdata = i_execute_data;
                            w_count = '0;
                            w_state = StAccess;
                        end
                        default: ;
                    endcase
                end
            end
            StAccess: begin
                if (i_dmem_ack) begin
                    w_mem_op   = r_is_sw ? OpSw : OpLw;
                    w_mem_ws   = r_ws;
                    w_mem_data = r_is_sw ? r_wdata : i_dmem_rdata;
                    w_state    = StIdle;
                end else if (r_count == LastCount) begin
                    w_error = 1'b1;
                    w_state = StIdle;
                end else begin
                    w_count = r_count + 8'd1;
                end
            end
            default: w_state = StIdle;
        endcase
    end

    assign o_stall         = (r_state == StAccess);
    assign o_dmem_req      = (r_state == StAccess);
    assign o_dmem_we       = (r_state == StAccess) && r_is_sw;
    assign o_dmem_address  = r_addr;
    assign o_dmem_wdata    = r_wdata;
    assign o_memory_opcode = r_mem_op;
    assign o_memory_ws     = r_mem_ws;
    assign o_memory_data   = r_mem_data;
    assign o_error         = r_error;

endmodule
